// File: rtl/lvp_table_if.sv
// Load value predictor handshake bundle: lookup/predict, resolve/train, flush,
// and recovery signalling between the MEM stage and lvp_table.
interface lvp_table_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                  lookup_valid;
    logic [ADDR_WIDTH-1:0] lookup_pc;
    logic                  lookup_ready;
    logic                  pred_valid;
    logic                  pred_hit;
    logic [DATA_WIDTH-1:0] pred_value;
    logic                  resolve_valid;
    logic [DATA_WIDTH-1:0] resolve_data;
    logic                  flush;
    logic                  recover;
    logic [ADDR_WIDTH-1:0] recover_pc;
    logic                  correct;
    logic [CNT_W-1:0]      outstanding;

    modport master (
        output lookup_valid, lookup_pc, resolve_valid, resolve_data, flush,
        input  lookup_ready, pred_valid, pred_hit, pred_value,
               recover, recover_pc, correct, outstanding
    );

    modport slave (
        input  lookup_valid, lookup_pc, resolve_valid, resolve_data, flush,
        output lookup_ready, pred_valid, pred_hit, pred_value,
               recover, recover_pc, correct, outstanding
    );
endinterface

// File: rtl/lvp_table.sv
// Tagged last-value load predictor with saturating confidence and an in-order
// queue of outstanding predictions, trained on every resolved load.
module lvp_table #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int INDEX_WIDTH     = 6,
    parameter int TAG_WIDTH       = 8,
    parameter int CONF_WIDTH      = 2,
    parameter int CONF_THRESH     = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         rst,
    lvp_table_if.slave   bus
);
    localparam int NUM_ENTRIES = 1 << INDEX_WIDTH;
    localparam int PTR_W       = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CONF_WIDTH-1:0] CONF_T   = CONF_WIDTH'(CONF_THRESH);
    localparam logic [CONF_WIDTH-1:0] CONF_MAX = {CONF_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    function automatic logic [INDEX_WIDTH-1:0] pc_index(input logic [ADDR_WIDTH-1:0] pc);
        return pc[INDEX_WIDTH+1:2];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] pc_tag(input logic [ADDR_WIDTH-1:0] pc);
        return pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
    endfunction

    function automatic logic [CONF_WIDTH-1:0] conf_sat_inc(input logic [CONF_WIDTH-1:0] c);
        return (c == CONF_MAX) ? c : c + CONF_WIDTH'(1);
    endfunction

    logic                  tbl_valid_r [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]  tbl_tag_r   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] tbl_value_r [NUM_ENTRIES];
    logic [CONF_WIDTH-1:0] tbl_conf_r  [NUM_ENTRIES];

    logic [ADDR_WIDTH-1:0] q_pc_r   [MAX_OUTSTANDING];
    logic                  q_pred_r [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0] q_val_r  [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    logic                  pred_valid_r;
    logic                  pred_hit_r;
    logic [DATA_WIDTH-1:0] pred_value_r;
    logic                  recover_r;
    logic [ADDR_WIDTH-1:0] recover_pc_r;
    logic                  correct_r;

    logic [INDEX_WIDTH-1:0] lk_idx_s;
    logic [TAG_WIDTH-1:0]   lk_tag_s;
    logic                   lk_conf_s;
    logic [DATA_WIDTH-1:0]  lk_value_s;
    logic                   full_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   res_s;
    logic [ADDR_WIDTH-1:0]  head_pc_s;
    logic                   head_pred_s;
    logic [DATA_WIDTH-1:0]  head_val_s;
    logic [INDEX_WIDTH-1:0] res_idx_s;
    logic [TAG_WIDTH-1:0]   res_tag_s;
    logic                   res_hit_s;
    logic                   res_same_s;
    logic                   mispred_s;
    logic                   verified_s;
    logic                   squash_s;
    logic [CNT_W-1:0]       cnt_nxt_s;

    // Lookup reads the table as it stands; a same-cycle training write is not bypassed.
    always_comb begin
        lk_idx_s   = pc_index(bus.lookup_pc);
        lk_tag_s   = pc_tag(bus.lookup_pc);
        lk_conf_s  = tbl_valid_r[lk_idx_s] && (tbl_tag_r[lk_idx_s] == lk_tag_s)
                     && (tbl_conf_r[lk_idx_s] >= CONF_T);
        if (lk_conf_s) begin
            lk_value_s = tbl_value_r[lk_idx_s];
        end else begin
            lk_value_s = {DATA_WIDTH{1'b0}};
        end

        full_s   = (count_r == CNT_FULL);
        ready_s  = ~full_s & ~bus.flush & ~recover_r;
        accept_s = bus.lookup_valid & ready_s;
        res_s    = bus.resolve_valid & (count_r != {CNT_W{1'b0}}) & ~bus.flush;

        head_pc_s   = q_pc_r[head_r];
        head_pred_s = q_pred_r[head_r];
        head_val_s  = q_val_r[head_r];
        res_idx_s   = pc_index(head_pc_s);
        res_tag_s   = pc_tag(head_pc_s);
        res_hit_s   = tbl_valid_r[res_idx_s] && (tbl_tag_r[res_idx_s] == res_tag_s);
        res_same_s  = (tbl_value_r[res_idx_s] == bus.resolve_data);

        mispred_s  = res_s & head_pred_s & (head_val_s != bus.resolve_data);
        verified_s = res_s & head_pred_s & (head_val_s == bus.resolve_data);
        squash_s   = bus.flush | mispred_s;

        if (squash_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            case ({accept_s, res_s})
                2'b10:   cnt_nxt_s = count_r + CNT_W'(1);
                2'b01:   cnt_nxt_s = count_r - CNT_W'(1);
                default: cnt_nxt_s = count_r;
            endcase
        end
    end

    // Table training on every resolved load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_valid_r[i] <= 1'b0;
                tbl_tag_r[i]   <= {TAG_WIDTH{1'b0}};
                tbl_value_r[i] <= {DATA_WIDTH{1'b0}};
                tbl_conf_r[i]  <= {CONF_WIDTH{1'b0}};
            end
        end else if (res_s) begin
            if (res_hit_s) begin
                if (res_same_s) begin
                    tbl_conf_r[res_idx_s] <= conf_sat_inc(tbl_conf_r[res_idx_s]);
                end else begin
                    tbl_value_r[res_idx_s] <= bus.resolve_data;
                    tbl_conf_r[res_idx_s]  <= {CONF_WIDTH{1'b0}};
                end
            end else begin
                tbl_valid_r[res_idx_s] <= 1'b1;
                tbl_tag_r[res_idx_s]   <= res_tag_s;
                tbl_value_r[res_idx_s] <= bus.resolve_data;
                tbl_conf_r[res_idx_s]  <= {CONF_WIDTH{1'b0}};
            end
        end else begin
            tbl_valid_r <= tbl_valid_r;
        end
    end

    // In-order prediction queue; a mispredict or flush drops every younger load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_pc_r[i]   <= {ADDR_WIDTH{1'b0}};
                q_pred_r[i] <= 1'b0;
                q_val_r[i]  <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            count_r <= cnt_nxt_s;
            if (squash_s) begin
                head_r <= {PTR_W{1'b0}};
                tail_r <= {PTR_W{1'b0}};
            end else begin
                if (accept_s) begin
                    q_pc_r[tail_r]   <= bus.lookup_pc;
                    q_pred_r[tail_r] <= lk_conf_s;
                    q_val_r[tail_r]  <= lk_value_s;
                    tail_r           <= tail_r + PTR_W'(1);
                end else begin
                    tail_r <= tail_r;
                end
                if (res_s) begin
                    head_r <= head_r + PTR_W'(1);
                end else begin
                    head_r <= head_r;
                end
            end
        end
    end

    // Registered prediction and resolve outcome pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_r <= 1'b0;
            pred_hit_r   <= 1'b0;
            pred_value_r <= {DATA_WIDTH{1'b0}};
            recover_r    <= 1'b0;
            recover_pc_r <= {ADDR_WIDTH{1'b0}};
            correct_r    <= 1'b0;
        end else begin
            pred_valid_r <= accept_s;
            pred_hit_r   <= accept_s & lk_conf_s;
            pred_value_r <= accept_s ? lk_value_s : {DATA_WIDTH{1'b0}};
            recover_r    <= mispred_s;
            correct_r    <= verified_s;
            if (mispred_s) begin
                recover_pc_r <= head_pc_s;
            end else begin
                recover_pc_r <= recover_pc_r;
            end
        end
    end

    assign bus.lookup_ready = ready_s;
    assign bus.pred_valid   = pred_valid_r;
    assign bus.pred_hit     = pred_hit_r;
    assign bus.pred_value   = pred_value_r;
    assign bus.recover      = recover_r;
    assign bus.recover_pc   = recover_pc_r;
    assign bus.correct      = correct_r;
    assign bus.outstanding  = count_r;
endmodule

// File: tb/tb_lvp_table.sv
// Directed bench for lvp_table: cold miss, training, mispredict, full/wrap,
// aliasing, flush and asynchronous reset, with hand-computed expectations.
module tb_lvp_table;
    localparam logic [31:0] PC0 = 32'h0040_0100;
    localparam logic [31:0] PC2 = 32'h0040_0200;
    localparam logic [31:0] PCA = 32'h0040_0114;
    localparam logic [31:0] PCB = 32'h0040_0118;
    localparam logic [31:0] PCX = 32'h0040_0218;
    localparam logic [31:0] VA  = 32'hA5A5_0001;
    localparam logic [31:0] VB  = 32'h5A5A_0002;

    logic clk = 1'b0;
    logic rst;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    lvp_table_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) bus ();

    lvp_table #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_WIDTH(6), .TAG_WIDTH(8),
        .CONF_WIDTH(2), .CONF_THRESH(3), .MAX_OUTSTANDING(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [31:0] pc, input logic rv,
                         input logic [31:0] rd, input logic fl);
        bus.lookup_valid  = lv;
        bus.lookup_pc     = pc;
        bus.resolve_valid = rv;
        bus.resolve_data  = rd;
        bus.flush         = fl;
        @(posedge clk);
        #1;
        bus.lookup_valid  = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_resolve(input logic [31:0] d);
        drive(1'b0, 32'h0, 1'b1, d, 1'b0);
    endtask

    task automatic check_pred(input string tag, input logic v, input logic h, input logic [31:0] val);
        check_eq({tag, "_valid"}, 32'(bus.pred_valid), 32'(v));
        check_eq({tag, "_hit"},   32'(bus.pred_hit),   32'(h));
        check_eq({tag, "_value"}, bus.pred_value,      val);
    endtask

    task automatic check_pulse(input string tag, input logic rc, input logic cr);
        check_eq({tag, "_recover"}, 32'(bus.recover), 32'(rc));
        check_eq({tag, "_correct"}, 32'(bus.correct), 32'(cr));
    endtask

    initial begin
        logic [31:0] cur_v;
        logic [31:0] nxt_pc;
        logic [31:0] nxt_v;

        rst = 1'b1;
        bus.lookup_valid  = 1'b0;
        bus.lookup_pc     = 32'h0;
        bus.resolve_valid = 1'b0;
        bus.resolve_data  = 32'h0;
        bus.flush         = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        check_pred("rst", 1'b0, 1'b0, 32'h0);
        check_pulse("rst", 1'b0, 1'b0);
        check_eq("rst_recover_pc", bus.recover_pc, 32'h0);
        check_eq("rst_outstanding", 32'(bus.outstanding), 32'd0);
        check_eq("rst_ready", 32'(bus.lookup_ready), 32'd1);

        // cold miss
        do_lookup(PC0);
        check_pred("cold", 1'b1, 1'b0, 32'h0);
        check_eq("cold_outstanding", 32'(bus.outstanding), 32'd1);
        do_resolve(32'hDEAD_BEEF);
        check_pulse("cold_res", 1'b0, 1'b0);
        check_eq("cold_res_outstanding", 32'(bus.outstanding), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_pred("pulse_len", 1'b0, 1'b0, 32'h0);

        // training: conf 0 (value replaced), 1, 2, 3
        for (int k = 0; k < 4; k++) begin
            do_lookup(PC0);
            check_pred("train", 1'b1, 1'b0, 32'h0);
            do_resolve(32'h0000_1234);
            check_pulse("train_res", 1'b0, 1'b0);
        end
        do_lookup(PC0);
        check_pred("trained", 1'b1, 1'b1, 32'h0000_1234);
        do_resolve(32'h0000_1234);
        check_pulse("trained_res", 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_pulse("trained_drop", 1'b0, 1'b0);

        // mispredict with a younger load in flight
        do_lookup(PC0);
        check_pred("mp_lk0", 1'b1, 1'b1, 32'h0000_1234);
        do_lookup(PC2);
        check_pred("mp_lk1", 1'b1, 1'b0, 32'h0);
        check_eq("mp_outstanding2", 32'(bus.outstanding), 32'd2);
        do_resolve(32'h0000_5678);
        check_pulse("mp", 1'b1, 1'b0);
        check_eq("mp_recover_pc", bus.recover_pc, PC0);
        check_eq("mp_outstanding0", 32'(bus.outstanding), 32'd0);
        check_eq("mp_ready_low", 32'(bus.lookup_ready), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_pulse("mp_drop", 1'b0, 1'b0);
        check_eq("mp_ready_back", 32'(bus.lookup_ready), 32'd1);
        check_eq("mp_recover_pc_hold", bus.recover_pc, PC0);
        do_lookup(PC0);
        check_pred("mp_retrained", 1'b1, 1'b0, 32'h0);
        do_resolve(32'h0000_5678);
        check_pulse("mp_retrained_res", 1'b0, 1'b0);

        // full queue
        do_lookup(32'h0040_0104);
        do_lookup(32'h0040_0108);
        do_lookup(32'h0040_010C);
        do_lookup(32'h0040_0110);
        check_eq("full_outstanding", 32'(bus.outstanding), 32'd4);
        check_eq("full_ready", 32'(bus.lookup_ready), 32'd0);
        do_lookup(32'h0040_0120);
        check_eq("full_reject_pred", 32'(bus.pred_valid), 32'd0);
        check_eq("full_reject_cnt", 32'(bus.outstanding), 32'd4);
        bus.lookup_valid  = 1'b1;
        bus.lookup_pc     = 32'h0040_0120;
        bus.resolve_valid = 1'b1;
        bus.resolve_data  = 32'h11;
        #1;
        check_eq("full_res_ready", 32'(bus.lookup_ready), 32'd0);
        drive(1'b1, 32'h0040_0120, 1'b1, 32'h11, 1'b0);
        check_eq("full_res_pred", 32'(bus.pred_valid), 32'd0);
        check_eq("full_res_cnt", 32'(bus.outstanding), 32'd3);
        check_eq("full_res_ready_after", 32'(bus.lookup_ready), 32'd1);
        do_resolve(32'h22);
        do_resolve(32'h33);
        do_resolve(32'h44);
        check_eq("full_drain", 32'(bus.outstanding), 32'd0);

        // train two neighbouring PCs to full confidence
        for (int k = 0; k < 4; k++) begin
            do_lookup(PCA);
            check_eq("trainA_hit", 32'(bus.pred_hit), 32'd0);
            do_resolve(VA);
            do_lookup(PCB);
            check_eq("trainB_hit", 32'(bus.pred_hit), 32'd0);
            do_resolve(VB);
        end

        // 10 overlapped lookup/resolve pairs, queue pointers wrapping
        do_lookup(PCA);
        check_pred("wrap_first", 1'b1, 1'b1, VA);
        cur_v = VA;
        for (int i = 0; i < 10; i++) begin
            nxt_pc = (i % 2 == 0) ? PCB : PCA;
            nxt_v  = (i % 2 == 0) ? VB : VA;
            drive(1'b1, nxt_pc, 1'b1, cur_v, 1'b0);
            check_pulse("wrap", 1'b0, 1'b1);
            check_pred("wrap", 1'b1, 1'b1, nxt_v);
            check_eq("wrap_outstanding", 32'(bus.outstanding), 32'd1);
            cur_v = nxt_v;
        end
        do_resolve(cur_v);
        check_pulse("wrap_last", 1'b0, 1'b1);
        check_eq("wrap_drain", 32'(bus.outstanding), 32'd0);

        // alias: same index as PCB, different tag
        do_lookup(PCX);
        check_pred("alias", 1'b1, 1'b0, 32'h0);
        do_resolve(32'h0000_ABCD);
        check_pulse("alias_res", 1'b0, 1'b0);
        do_lookup(PCB);
        check_pred("alias_evicted", 1'b1, 1'b0, 32'h0);
        do_resolve(VB);
        check_pulse("alias_evicted_res", 1'b0, 1'b0);

        // flush with three outstanding, plus a same-cycle resolve that must be ignored
        do_lookup(PCA);
        do_lookup(PCA);
        do_lookup(PCA);
        check_pred("fl_lk", 1'b1, 1'b1, VA);
        check_eq("fl_outstanding3", 32'(bus.outstanding), 32'd3);
        bus.flush         = 1'b1;
        bus.resolve_valid = 1'b1;
        bus.resolve_data  = 32'h0000_0BAD;
        #1;
        check_eq("fl_ready_low", 32'(bus.lookup_ready), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0BAD, 1'b1);
        check_eq("fl_outstanding0", 32'(bus.outstanding), 32'd0);
        check_pulse("fl", 1'b0, 1'b0);
        do_resolve(32'h0000_0BAD);
        check_pulse("fl_empty_res", 1'b0, 1'b0);
        check_eq("fl_empty_cnt", 32'(bus.outstanding), 32'd0);
        do_lookup(PCA);
        check_pred("fl_table_kept", 1'b1, 1'b1, VA);
        do_resolve(VA);
        check_pulse("fl_table_kept_res", 1'b0, 1'b1);

        // asynchronous reset between edges
        do_lookup(PCA);
        check_pred("ar_pre", 1'b1, 1'b1, VA);
        #1 rst = 1'b1;
        #1;
        check_pred("ar", 1'b0, 1'b0, 32'h0);
        check_pulse("ar", 1'b0, 1'b0);
        check_eq("ar_recover_pc", bus.recover_pc, 32'h0);
        check_eq("ar_outstanding", 32'(bus.outstanding), 32'd0);
        #1 rst = 1'b0;
        do_lookup(PCA);
        check_pred("ar_cold", 1'b1, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
